// File: rtl/shift_register_165.sv
// shift_register_165: reads a daisy chain of 74HC165 shift registers into a parallel word
module shift_register_165 #(
  parameter int NUM_ICS = 2,
  parameter int CLK_DIV = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   trigger_i,
  input  logic                   data_i,
  output logic                   sclk_o,
  output logic                   load_n_o,
  output logic [NUM_ICS*8-1:0]   data_o,
  output logic                   valid_o,
  output logic                   busy_o
);
  localparam int N  = NUM_ICS * 8;
  localparam int BW = $clog2(N);
  localparam int DW = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, LOW, HIGH} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [N-1:0]    shift_q, shift_d;
  logic [N-1:0]    data_q, data_d;
  logic            valid_q, valid_d;
  logic            sclk_q, sclk_d;
  logic            load_n_q, load_n_d;
  logic            busy_q, busy_d;
  logic            last_div;

  assign last_div = div_q == DW'(CLK_DIV - 1);

  // Sequence the load/settle/clock phases; pin outputs follow the next state so they are registered
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (state_q != IDLE) div_d = last_div ? '0 : div_q + 1'b1;
    case (state_q)
      IDLE: if (trigger_i) begin
        state_d = LOAD;
        div_d   = '0;
        bit_d   = '0;
      end
      LOAD:   if (last_div) state_d = SETTLE;
      SETTLE: if (last_div) state_d = LOW;
      LOW: if (last_div) begin
        shift_d = {shift_q[N-2:0], data_i};
        state_d = HIGH;
      end
      HIGH: if (last_div) begin
        if (bit_q == BW'(N - 1)) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          bit_d   = bit_q + 1'b1;
          state_d = LOW;
        end
      end
      default: state_d = IDLE;
    endcase
    sclk_d   = state_d == HIGH;
    load_n_d = state_d != LOAD;
    busy_d   = state_d != IDLE;
  end

  // State and output registers; reset aborts any frame without publishing it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sclk_q   <= 1'b0;
      load_n_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sclk_q   <= sclk_d;
      load_n_q <= load_n_d;
      busy_q   <= busy_d;
    end
  end

  assign sclk_o   = sclk_q;
  assign load_n_o = load_n_q;
  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign busy_o   = busy_q;
endmodule
